scan_mux: RTL and testbench
===========================

SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 The block SHALL have parameter W, default 1, meaning data width per channel in bits (W >= 1).
REQ-002 The block SHALL have parameter N, default 4, meaning number of input channels (2 <= N <= 16).
REQ-003 The block SHALL have parameter DWELL, default 4, meaning clock cycles spent on each channel in scan mode (DWELL >= 1).
REQ-004 The block SHALL have parameter INVERT, default 1, meaning 1 = active-low data output (ybar style), 0 = true output.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-007 The block SHALL have port din, input, N*W, meaning channel data; channel k occupies bits [k*W +: W].
REQ-008 The block SHALL have port sel, input, SW = max(1, clog2(N)), meaning manual channel select.
REQ-009 The block SHALL have port en, input, 1, meaning enable; 0 = output idle, scan frozen.
REQ-010 The block SHALL have port mode, input, 1, meaning 0 = MANUAL, 1 = SCAN.
REQ-011 The block SHALL have port y, output, W, meaning registered selected data (inverted when INVERT = 1).
REQ-012 The block SHALL have port ch, output, SW, meaning channel index that y currently reflects.
REQ-013 The block SHALL have port valid, output, 1, meaning y holds selected channel data.

Function
REQ-014 The idle value IDLE SHALL be all-ones when INVERT = 1 and all-zeros when INVERT = 0.
REQ-015 y, ch and valid SHALL be registered with a latency of 1 cycle from inputs to outputs.
REQ-016 In MANUAL mode with en = 1 and sel < N, the block SHALL register y = din[sel] (inverted per INVERT), ch = sel and valid = 1.
REQ-017 In MANUAL mode with en = 1 and sel >= N (N not a power of 2), the block SHALL register y = IDLE and valid = 0, and ch SHALL hold its previous value.
REQ-018 In SCAN mode with en = 1, y SHALL reflect din[scan_ch] and ch = scan_ch, with valid = 1, using the live din value on each cycle.
REQ-019 The dwell counter SHALL count 0..DWELL-1; at DWELL-1 it SHALL wrap to 0 and scan_ch SHALL advance by 1.
REQ-020 scan_ch SHALL wrap from N-1 to 0.
REQ-021 A 0->1 transition on mode, sampled at a clock edge, SHALL load scan_ch = 0 and dwell = 0, so channel 0 is output for DWELL full cycles.
REQ-022 In SCAN mode, the cycle-accurate sequence of ch SHALL be 0 repeated DWELL times, then 1 repeated DWELL times, and so on.
REQ-023 With en = 0 in either mode, the block SHALL register y = IDLE and valid = 0, and ch, scan_ch and dwell SHALL hold their values.
REQ-024 When en returns to 1 in SCAN mode, scanning SHALL resume from the frozen scan_ch and dwell values.
REQ-025 In MANUAL mode, scan_ch and dwell SHALL hold their values; they are only reloaded on entry to SCAN mode.
REQ-026 If a mode change and an en change occur in the same cycle, en SHALL take priority: with en = 0 the counters freeze, but the mode-entry reload (REQ-021) SHALL still occur.

Reset
REQ-027 While rst = 1, y SHALL be IDLE, valid SHALL be 0, ch SHALL be 0, scan_ch SHALL be 0 and dwell SHALL be 0, immediately and without waiting for a clock edge.
REQ-028 Assertion of rst mid-scan SHALL discard the scan position, and scanning SHALL restart at channel 0 on the first enabled edge after release.
REQ-029 The previous mode register SHALL reset to MANUAL, so mode = 1 at reset release counts as SCAN entry.

Structure
REQ-030 The shared package scan_mux_pkg SHALL hold the mode typedef (MODE_MANUAL = 0, MODE_SCAN = 1) and a function computing SW from N.
REQ-031 The block SHALL instantiate one sub-module, dwell_counter, parametrised by DWELL and N, with inputs clk, rst, en, load and outputs scan_ch, wrap.
REQ-032 The data selection SHALL be a combinational indexed part-select feeding the output registers, with no latches.

Verification
REQ-033 The bench SHALL cover: W=1, N=2, INVERT=1, MANUAL, din=2'b11, en 1->0 -> y=1, valid=0 one cycle after en falls, ch held.
REQ-034 The bench SHALL cover: W=8, N=4, MANUAL, din={8'h44,8'h33,8'h22,8'h11}, INVERT=0, sel stepped 0..3 -> y = 11, 22, 33, 44 each one cycle after sel changes.
REQ-035 The bench SHALL cover: N=4, DWELL=3, SCAN entered at cycle t -> ch = 0,0,0,1,1,1,2,2,2,3,3,3,0 starting at t+1.
REQ-036 The bench SHALL cover: SCAN with en=0 for 5 cycles at ch=2, dwell=1 -> y=IDLE, valid=0 while low; after re-enable ch=2 for 1 more cycle (DWELL=3), then 3.
REQ-037 The bench SHALL cover: N=3, MANUAL, sel=3 -> y=IDLE, valid=0, ch unchanged.
REQ-038 The bench SHALL cover: rst pulsed asynchronously mid-scan at ch=3 -> y=IDLE, valid=0, ch=0 immediately; after release SCAN restarts at ch=0.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the scan_mux channel selector.
package scan_mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Width of a channel index: max(1, clog2(n)).
  function automatic int unsigned calc_sw(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Scan position tracker: holds each channel for DWELL cycles, then steps to the
// next channel, wrapping from N-1 back to 0. The registered position is the one
// currently shown on the scan_mux outputs.
module dwell_counter
  import scan_mux_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned N     = 4,
  localparam int unsigned SW   = calc_sw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  output logic [SW-1:0] scan_ch,
  output logic          wrap
);

  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] ch_q, ch_d;

  // Last cycle of the current channel's dwell window.
  assign wrap    = (dwell_q == DW'(DWELL - 1));
  assign scan_ch = ch_q;

  // Next position: reload on scan entry, otherwise advance only when enabled.
  always_comb begin
    dwell_d = dwell_q;
    ch_d    = ch_q;
    if (load) begin
      dwell_d = '0;
      ch_d    = '0;
    end else if (en) begin
      if (wrap) begin
        dwell_d = '0;
        ch_d    = (ch_q == SW'(N - 1)) ? '0 : ch_q + SW'(1);
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
      ch_q    <= '0;
    end else begin
      dwell_q <= dwell_d;
      ch_q    <= ch_d;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered N-to-1 channel selector with manual select and automatic scan.
// Output y is optionally active-low; when not carrying data it sits at IDLE.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int unsigned W      = 1,
  parameter int unsigned N      = 4,
  parameter int unsigned DWELL  = 4,
  parameter int unsigned INVERT = 1,
  localparam int unsigned SW    = calc_sw(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  din,
  input  logic [SW-1:0]   sel,
  input  logic            en,
  input  logic            mode,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   ch,
  output logic            valid
);

  // XOR with IDLE doubles as the optional inversion of selected data.
  localparam logic [W-1:0] IDLE = (INVERT != 0) ? {W{1'b1}} : {W{1'b0}};
  localparam int unsigned NP    = 2 ** SW;

  mode_e           mode_q;
  logic            scanning;
  logic            entry;
  logic [SW-1:0]   scan_ch;
  logic            wrap;
  logic [SW-1:0]   next_ch;
  logic [SW-1:0]   idx;
  logic            sel_ok;
  logic [NP*W-1:0] din_pad;
  logic [W-1:0]    pick;

  logic [W-1:0]    y_q, y_d;
  logic [SW-1:0]   ch_q, ch_d;
  logic            valid_q, valid_d;

  assign scanning = (mode == MODE_SCAN);
  assign entry    = scanning && (mode_q == MODE_MANUAL);
  assign sel_ok   = (32'(sel) < N);

  dwell_counter #(
    .DWELL (DWELL),
    .N     (N)
  ) u_dwell_counter (
    .clk     (clk),
    .rst     (rst),
    .en      (en && scanning),
    .load    (entry),
    .scan_ch (scan_ch),
    .wrap    (wrap)
  );

  // Channel the scan will show after this edge (mirrors the counter's next state).
  always_comb begin
    next_ch = scan_ch;
    if (entry) begin
      next_ch = '0;
    end else if (wrap) begin
      next_ch = (scan_ch == SW'(N - 1)) ? '0 : scan_ch + SW'(1);
    end
  end

  // Pad din to a power-of-two channel count so an out-of-range sel stays in bounds.
  always_comb begin
    din_pad          = '0;
    din_pad[N*W-1:0] = din;
    idx              = scanning ? next_ch : sel;
    pick             = din_pad[idx*W +: W];
  end

  // Output next-state: idle unless enabled with a valid channel.
  always_comb begin
    y_d     = IDLE;
    ch_d    = ch_q;
    valid_d = 1'b0;
    if (en) begin
      if (scanning) begin
        y_d     = pick ^ IDLE;
        ch_d    = next_ch;
        valid_d = 1'b1;
      end else if (sel_ok) begin
        y_d     = pick ^ IDLE;
        ch_d    = sel;
        valid_d = 1'b1;
      end
    end
  end

  // Output and previous-mode registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= IDLE;
      ch_q    <= '0;
      valid_q <= 1'b0;
      mode_q  <= MODE_MANUAL;
    end else begin
      y_q     <= y_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      mode_q  <= mode_e'(mode);
    end
  end

  assign y     = y_q;
  assign ch    = ch_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux using three parameterisations side by side.
module tb_scan_mux;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // a: W=1 N=2 DWELL=4 INVERT=1
  logic [1:0]  din_a;
  logic [0:0]  sel_a;
  logic        en_a, mode_a;
  logic [0:0]  y_a;
  logic [0:0]  ch_a;
  logic        valid_a;

  // b: W=8 N=4 DWELL=3 INVERT=0
  logic [31:0] din_b;
  logic [1:0]  sel_b;
  logic        en_b, mode_b;
  logic [7:0]  y_b;
  logic [1:0]  ch_b;
  logic        valid_b;

  // c: W=4 N=3 DWELL=2 INVERT=1
  logic [11:0] din_c;
  logic [1:0]  sel_c;
  logic        en_c, mode_c;
  logic [3:0]  y_c;
  logic [1:0]  ch_c;
  logic        valid_c;

  scan_mux #(.W(1), .N(2), .DWELL(4), .INVERT(1)) u_a (
    .clk(clk), .rst(rst), .din(din_a), .sel(sel_a), .en(en_a), .mode(mode_a),
    .y(y_a), .ch(ch_a), .valid(valid_a)
  );

  scan_mux #(.W(8), .N(4), .DWELL(3), .INVERT(0)) u_b (
    .clk(clk), .rst(rst), .din(din_b), .sel(sel_b), .en(en_b), .mode(mode_b),
    .y(y_b), .ch(ch_b), .valid(valid_b)
  );

  scan_mux #(.W(4), .N(3), .DWELL(2), .INVERT(1)) u_c (
    .clk(clk), .rst(rst), .din(din_c), .sel(sel_c), .en(en_c), .mode(mode_c),
    .y(y_c), .ch(ch_c), .valid(valid_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bytes_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int         seq_b   [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  initial begin
    rst    = 1'b1;
    din_a  = 2'b11; sel_a = 1'b0; en_a = 1'b0; mode_a = 1'b0;
    din_b  = {8'h44, 8'h33, 8'h22, 8'h11}; sel_b = 2'd0; en_b = 1'b0; mode_b = 1'b0;
    din_c  = {4'hC, 4'hB, 4'hA}; sel_c = 2'd0; en_c = 1'b0; mode_c = 1'b0;
    #1;
    check("rst_y_a", 32'(y_a), 32'h1);
    check("rst_y_b", 32'(y_b), 32'h0);
    check("rst_valid_b", 32'(valid_b), 32'h0);
    check("rst_ch_b", 32'(ch_b), 32'h0);
    #11;
    rst = 1'b0;

    // Manual, inverted 1-bit: enabled then disabled.
    sel_a = 1'b1; en_a = 1'b1;
    // Manual, N=3: valid channel first.
    sel_c = 2'd1; en_c = 1'b1;
    tick();
    check("a_on_y", 32'(y_a), 32'h0);
    check("a_on_valid", 32'(valid_a), 32'h1);
    check("a_on_ch", 32'(ch_a), 32'h1);
    check("c_sel1_y", 32'(y_c), 32'h4);
    check("c_sel1_ch", 32'(ch_c), 32'h1);
    en_a  = 1'b0;
    sel_c = 2'd3;
    tick();
    check("a_off_y", 32'(y_a), 32'h1);
    check("a_off_valid", 32'(valid_a), 32'h0);
    check("a_off_ch", 32'(ch_a), 32'h1);
    check("c_sel3_y", 32'(y_c), 32'hF);
    check("c_sel3_valid", 32'(valid_c), 32'h0);
    check("c_sel3_ch", 32'(ch_c), 32'h1);

    // Manual, 8-bit true output: step sel 0..3.
    en_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel_b = 2'(k);
      tick();
      check("b_man_y", 32'(y_b), 32'(bytes_b[k]));
      check("b_man_ch", 32'(ch_b), 32'(k));
      check("b_man_valid", 32'(valid_b), 32'h1);
    end

    // Scan entry: each channel for DWELL=3 cycles.
    mode_b = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      check("b_scan_ch", 32'(ch_b), 32'(seq_b[i]));
      check("b_scan_y", 32'(y_b), 32'(bytes_b[seq_b[i]]));
      check("b_scan_valid", 32'(valid_b), 32'h1);
    end
    // Advance to the second cycle of channel 2, with live din change on the way.
    din_b[23:16] = 8'h5A;
    for (int i = 0; i < 7; i++) tick();
    check("b_pre_frz_ch", 32'(ch_b), 32'h2);
    check("b_pre_frz_y", 32'(y_b), 32'h5A);

    // Freeze for 5 cycles.
    en_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_frz_y", 32'(y_b), 32'h0);
      check("b_frz_valid", 32'(valid_b), 32'h0);
      check("b_frz_ch", 32'(ch_b), 32'h2);
    end
    en_b = 1'b1;
    tick();
    check("b_resume_ch2", 32'(ch_b), 32'h2);
    check("b_resume_valid", 32'(valid_b), 32'h1);
    tick();
    check("b_resume_ch3", 32'(ch_b), 32'h3);
    check("b_resume_y", 32'(y_b), 32'h44);

    // Asynchronous reset mid-scan at channel 3.
    #2;
    rst = 1'b1;
    #1;
    check("b_arst_y", 32'(y_b), 32'h0);
    check("b_arst_valid", 32'(valid_b), 32'h0);
    check("b_arst_ch", 32'(ch_b), 32'h0);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b_restart_ch", 32'(ch_b), (i < 3) ? 32'h0 : 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
